// File: rtl/mrav_uart_tx.sv
// mrav_uart_tx: byte-wide register slave driving an 8N1 UART transmitter with a programmable bit divider.
// Build option MRAV_UART_TX_FIFO_EN selects a 4-entry transmit FIFO instead of a single holding register.
module mrav_uart_tx #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_done,
    output logic                  write_done,
    output logic                  tx
);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [7:0] pack_status(input logic busy, input logic full,
                                               input logic empty, input logic ovf);
        return {4'b0000, ovf, empty, full, busy};
    endfunction

    // bus handshake and register file
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  busy_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic [DATA_WIDTH-1:0] div_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  read_done_r;
    logic                  write_done_r;
    logic                  ovf_r;
    logic                  addr_unused_s;

    // shifter
    tx_state_e             state_r;
    tx_state_e             state_nxt_s;
    logic [7:0]            bit_cnt_r;
    logic [7:0]            bit_cnt_nxt_s;
    logic [7:0]            bit_div_r;
    logic [7:0]            bit_div_nxt_s;
    logic [2:0]            bit_idx_r;
    logic [2:0]            bit_idx_nxt_s;
    logic [7:0]            shreg_r;
    logic [7:0]            shreg_nxt_s;
    logic                  bit_end_s;
    logic                  tx_r;
    logic                  tx_nxt_s;

    assign addr_unused_s = &{1'b0, addr[ADDR_WIDTH-1:2]};

    // A request seen while its own done is high is the tail of the previous access.
    // A simultaneous read is held off so only the write is served.
    assign wr_acc_s = write & ~write_done_r;
    assign rd_acc_s = read & ~write & ~read_done_r;

    // full_s comes from registered state, so it reflects occupancy before any same-cycle pop
    assign push_s = wr_acc_s & (addr[1:0] == REG_DATA) & ~full_s;
    assign drop_s = wr_acc_s & (addr[1:0] == REG_DATA) & full_s;
    assign busy_s = (state_r != ST_IDLE);

`ifdef MRAV_UART_TX_FIFO_EN
    logic [DATA_WIDTH-1:0] fifo_mem_r [0:3];
    logic [1:0]            wr_ptr_r;
    logic [1:0]            rd_ptr_r;
    logic [2:0]            count_r;

    assign full_s  = (count_r == 3'd4);
    assign empty_s = (count_r == 3'd0);
    assign head_s  = fifo_mem_r[rd_ptr_r];

    // transmit FIFO storage, wrap-around pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= data_in;
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end
`else
    logic [DATA_WIDTH-1:0] hold_r;
    logic                  hold_vld_r;

    assign full_s  = hold_vld_r;
    assign empty_s = ~hold_vld_r;
    assign head_s  = hold_r;

    // single holding register; push needs it empty and pop needs it full, so they never coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r     <= '0;
            hold_vld_r <= 1'b0;
        end else if (push_s) begin
            hold_r     <= data_in;
            hold_vld_r <= 1'b1;
        end else if (pop_s) begin
            hold_vld_r <= 1'b0;
        end
    end
`endif

    // read data multiplexer
    always_comb begin
        rdata_s = '0;
        case (addr[1:0])
            REG_STATUS: rdata_s = pack_status(busy_s, full_s, empty_s, ovf_r);
            REG_DIV:    rdata_s = div_r;
            default:    rdata_s = '0;
        endcase
    end

    // completion pulses, read data, divider and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_done_r  <= 1'b0;
            write_done_r <= 1'b0;
            data_out_r   <= '0;
            div_r        <= 8'd15;
            ovf_r        <= 1'b0;
        end else begin
            read_done_r  <= rd_acc_s;
            write_done_r <= wr_acc_s;
            if (rd_acc_s) begin
                data_out_r <= rdata_s;
            end
            if (wr_acc_s && (addr[1:0] == REG_DIV)) begin
                div_r <= data_in;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (rd_acc_s && (addr[1:0] == REG_STATUS)) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // bit_div_r is reloaded from div_r only at bit boundaries so a divider change never cuts a bit short
    assign bit_end_s = (bit_cnt_r == bit_div_r);

    // shifter next-state, bit timing and buffer pop
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r + 8'd1;
        bit_idx_nxt_s = bit_idx_r;
        shreg_nxt_s   = shreg_r;
        bit_div_nxt_s = bit_div_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bit_cnt_nxt_s = 8'd0;
                if (!empty_s) begin
                    pop_s         = 1'b1;
                    state_nxt_s   = ST_START;
                    shreg_nxt_s   = head_s;
                    bit_div_nxt_s = div_r;
                    bit_idx_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s   = ST_DATA;
                    bit_cnt_nxt_s = 8'd0;
                    bit_idx_nxt_s = 3'd0;
                    bit_div_nxt_s = div_r;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    bit_cnt_nxt_s = 8'd0;
                    bit_div_nxt_s = div_r;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                        shreg_nxt_s   = {1'b0, shreg_r[7:1]};
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    bit_cnt_nxt_s = 8'd0;
                    bit_div_nxt_s = div_r;
                    if (!empty_s) begin
                        pop_s         = 1'b1;
                        state_nxt_s   = ST_START;
                        shreg_nxt_s   = head_s;
                        bit_idx_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                bit_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // line level follows the state being entered so tx changes on the same edge as the state
    always_comb begin
        tx_nxt_s = 1'b1;
        case (state_nxt_s)
            ST_IDLE:  tx_nxt_s = 1'b1;
            ST_START: tx_nxt_s = 1'b0;
            ST_DATA:  tx_nxt_s = shreg_nxt_s[0];
            ST_STOP:  tx_nxt_s = 1'b1;
            default:  tx_nxt_s = 1'b1;
        endcase
    end

    // shifter state and serial output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 8'd0;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'd0;
            bit_div_r <= 8'd15;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shreg_r   <= shreg_nxt_s;
            bit_div_r <= bit_div_nxt_s;
            tx_r      <= tx_nxt_s;
        end
    end

    assign data_out   = data_out_r;
    assign read_done  = read_done_r;
    assign write_done = write_done_r;
    assign tx         = tx_r;

endmodule
